// File: rtl/border_flood_pkg.sv
// Shared definitions for the border-discovery flood engine.
`ifndef T_D_WIDTH
`define T_D_WIDTH 32
`endif

package border_flood_pkg;

  // Flit field positions (LSB of each field)
  localparam int unsigned TYPE_LSB = 26;
  localparam int unsigned XMIN_LSB = 23;
  localparam int unsigned YMIN_LSB = 20;
  localparam int unsigned XMAX_LSB = 17;
  localparam int unsigned YMAX_LSB = 14;
  localparam int unsigned SRCX_LSB = 11;
  localparam int unsigned SRCY_LSB = 8;
  localparam int unsigned HOP_LSB  = 4;

  localparam int unsigned CRD_W   = 3;
  localparam int unsigned HOP_W   = 4;
  localparam int unsigned FIELD_W = 29;
  localparam int unsigned NPORT   = 4;

  localparam logic [2:0] BORDER_TYPE = 3'b101;

  // Router phase codes
  localparam logic [2:0] PH_INIT   = 3'b000;
  localparam logic [2:0] PH_BORDER = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ANNOUNCE = 2'd1,
    ST_RELAY    = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    P_N = 2'd0,
    P_E = 2'd1,
    P_S = 2'd2,
    P_W = 2'd3
  } port_e;

  // Build the low FIELD_W bits of a border flit from its fields.
  function automatic logic [FIELD_W-1:0] make_border(
    input logic [CRD_W-1:0] x_min,
    input logic [CRD_W-1:0] y_min,
    input logic [CRD_W-1:0] x_max,
    input logic [CRD_W-1:0] y_max,
    input logic [CRD_W-1:0] src_x,
    input logic [CRD_W-1:0] src_y,
    input logic [HOP_W-1:0] hop
  );
    logic [FIELD_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: 3]     = BORDER_TYPE;
    f[XMIN_LSB +: CRD_W] = x_min;
    f[YMIN_LSB +: CRD_W] = y_min;
    f[XMAX_LSB +: CRD_W] = x_max;
    f[YMAX_LSB +: CRD_W] = y_max;
    f[SRCX_LSB +: CRD_W] = src_x;
    f[SRCY_LSB +: CRD_W] = src_y;
    f[HOP_LSB +: HOP_W]  = hop;
    return f;
  endfunction

endpackage

// File: rtl/bf_fifo2.sv
// Two-entry synchronous FIFO; a push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module bf_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/border_flood.sv
// Border-discovery flood engine: announces own flit, relays first copy of every other node's flit.
module border_flood
  import border_flood_pkg::*;
#(
  parameter int unsigned WIDTHX    = 6,
  parameter int unsigned WIDTHY    = 6,
  parameter int unsigned T_D_WIDTH = `T_D_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           state,
  input  logic [2:0]           my_x,
  input  logic [2:0]           my_y,
  input  logic [T_D_WIDTH-1:0] n_in,
  input  logic [T_D_WIDTH-1:0] e_in,
  input  logic [T_D_WIDTH-1:0] s_in,
  input  logic [T_D_WIDTH-1:0] w_in,
  input  logic                 n_rdy,
  input  logic                 e_rdy,
  input  logic                 s_rdy,
  input  logic                 w_rdy,
  output logic [T_D_WIDTH-1:0] n_out,
  output logic [T_D_WIDTH-1:0] e_out,
  output logic [T_D_WIDTH-1:0] s_out,
  output logic [T_D_WIDTH-1:0] w_out,
  output logic [5:0]           seen_count,
  output logic                 overflow
);

  localparam int unsigned SEEN_W  = WIDTHX * WIDTHY;
  localparam int unsigned IDX_W   = $clog2(SEEN_W);
  localparam int unsigned HOP_MAX = WIDTHX + WIDTHY - 2;
  localparam int unsigned CNT_W   = 6;

  logic [T_D_WIDTH-1:0] in_w   [NPORT];
  logic [T_D_WIDTH-1:0] head_w [NPORT];
  logic [T_D_WIDTH-1:0] out_q  [NPORT];
  logic [T_D_WIDTH-1:0] out_d  [NPORT];
  logic [NPORT-1:0]     rdy_w, is_edge, push_w, pop_w, full_w, empty_w;

  fsm_state_e        fsm_q, fsm_d;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic                 in_border;
  logic [T_D_WIDTH-1:0] own_w;
  logic [IDX_W-1:0]     self_idx;

  logic                 win_ok;
  logic [1:0]           win;
  logic [T_D_WIDTH-1:0] head;
  logic [T_D_WIDTH-1:0] fwd_flit;
  logic [HOP_W:0]       hop_nxt;
  logic [CRD_W-1:0]     src_x, src_y;
  logic [IDX_W-1:0]     src_idx;
  logic                 src_ok, drop, fwd, free;
  logic [NPORT-1:0]     tgt;

  assign in_w[P_N] = n_in;
  assign in_w[P_E] = e_in;
  assign in_w[P_S] = s_in;
  assign in_w[P_W] = w_in;
  assign rdy_w = {w_rdy, s_rdy, e_rdy, n_rdy};

  // Mesh-boundary ports have no neighbour
  assign is_edge[P_N] = (my_y == 3'd0);
  assign is_edge[P_S] = (my_y == 3'(WIDTHY - 1));
  assign is_edge[P_W] = (my_x == 3'd0);
  assign is_edge[P_E] = (my_x == 3'(WIDTHX - 1));

  assign in_border = (state == PH_BORDER);
  assign own_w     = T_D_WIDTH'(make_border(my_x, my_y, my_x, my_y, my_x, my_y, 4'd0));
  assign self_idx  = IDX_W'(32'(my_y) * WIDTHX + 32'(my_x));

  // Capture valid non-edge arrivals while discovery is running
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      push_w[p] = in_border && (fsm_q != ST_IDLE) && !is_edge[p] && (in_w[p] != '0);
    end
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_fifo
    bf_fifo2 #(.W(T_D_WIDTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear_i (!in_border),
      .push_i  (push_w[g]),
      .pop_i   (pop_w[g]),
      .data_i  (in_w[g]),
      .data_o  (head_w[g]),
      .full_o  (full_w[g]),
      .empty_o (empty_w[g])
    );
  end

  // Next-state: arbitration, drop/relay decision and output register loading
  always_comb begin
    fsm_d  = fsm_q;
    seen_d = seen_q;
    cnt_d  = cnt_q;
    pop_w  = '0;
    tgt    = '0;
    free   = 1'b1;
    win_ok = 1'b0;
    win    = 2'd0;
    for (int p = NPORT - 1; p >= 0; p--) begin
      if (!empty_w[p]) begin
        win_ok = 1'b1;
        win    = 2'(p);
      end
    end
    head     = head_w[win];
    hop_nxt  = (HOP_W+1)'(head[HOP_LSB +: HOP_W]) + (HOP_W+1)'(1);
    src_x    = head[SRCX_LSB +: CRD_W];
    src_y    = head[SRCY_LSB +: CRD_W];
    src_ok   = (32'(src_x) < WIDTHX) && (32'(src_y) < WIDTHY);
    src_idx  = IDX_W'(32'(src_y) * WIDTHX + 32'(src_x));
    drop     = (head[TYPE_LSB +: 3] != BORDER_TYPE) || !src_ok || seen_q[src_idx];
    fwd      = (32'(hop_nxt) <= HOP_MAX);
    fwd_flit = head;
    fwd_flit[HOP_LSB +: HOP_W] = hop_nxt[HOP_W-1:0];
    for (int p = 0; p < NPORT; p++) begin
      tgt[p]   = fwd && !is_edge[p] && (2'(p) != win);
      if (tgt[p] && (out_q[p] != '0) && !rdy_w[p]) free = 1'b0;
      out_d[p] = rdy_w[p] ? '0 : out_q[p];
    end

    case (fsm_q)
      ST_IDLE: begin
        if (in_border) fsm_d = ST_ANNOUNCE;
      end
      ST_ANNOUNCE: begin
        for (int p = 0; p < NPORT; p++) begin
          if (!is_edge[p]) out_d[p] = own_w;
        end
        seen_d[self_idx] = 1'b1;
        cnt_d            = CNT_W'(1);
        fsm_d            = ST_RELAY;
      end
      ST_RELAY: begin
        if (win_ok) begin
          if (drop) begin
            pop_w[win] = 1'b1;
          end else if (free) begin
            pop_w[win]      = 1'b1;
            seen_d[src_idx] = 1'b1;
            cnt_d           = cnt_q + CNT_W'(1);
            for (int p = 0; p < NPORT; p++) begin
              if (tgt[p]) out_d[p] = fwd_flit;
            end
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    if (!in_border) begin
      fsm_d  = ST_IDLE;
      seen_d = '0;
      cnt_d  = '0;
      pop_w  = '0;
      for (int p = 0; p < NPORT; p++) out_d[p] = '0;
    end
  end

  // Sticky overflow: survives leaving discovery, cleared by the init phase
  always_comb begin
    ovf_d = ovf_q | (|(push_w & full_w & ~pop_w));
    if (state == PH_INIT) ovf_d = 1'b0;
  end

  // State, bitmap, counter and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q  <= ST_IDLE;
      seen_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      for (int p = 0; p < NPORT; p++) out_q[p] <= '0;
    end else begin
      fsm_q  <= fsm_d;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      for (int p = 0; p < NPORT; p++) out_q[p] <= out_d[p];
    end
  end

  assign n_out      = out_q[P_N];
  assign e_out      = out_q[P_E];
  assign s_out      = out_q[P_S];
  assign w_out      = out_q[P_W];
  assign seen_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_border_flood.sv
// Scoreboard bench for border_flood: per-port expected queues, popped on each output handshake.
module tb_border_flood;

  logic        clk;
  logic        reset;
  logic [2:0]  state, my_x, my_y;
  logic [31:0] n_in, e_in, s_in, w_in;
  logic        n_rdy, e_rdy, s_rdy, w_rdy;
  logic [31:0] n_out, e_out, s_out, w_out;
  logic [5:0]  seen_count;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] qn[$], qe[$], qs[$], qw[$];
  logic [31:0] outs [4];
  logic [3:0]  rdys;

  border_flood #(.WIDTHX(6), .WIDTHY(6), .T_D_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .state(state), .my_x(my_x), .my_y(my_y),
    .n_in(n_in), .e_in(e_in), .s_in(s_in), .w_in(w_in),
    .n_rdy(n_rdy), .e_rdy(e_rdy), .s_rdy(s_rdy), .w_rdy(w_rdy),
    .n_out(n_out), .e_out(e_out), .s_out(s_out), .w_out(w_out),
    .seen_count(seen_count), .overflow(overflow)
  );

  assign outs[0] = n_out;
  assign outs[1] = e_out;
  assign outs[2] = s_out;
  assign outs[3] = w_out;
  assign rdys    = {w_rdy, s_rdy, e_rdy, n_rdy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] ty, input logic [2:0] xmn, input logic [2:0] ymn,
                                     input logic [2:0] xmx, input logic [2:0] ymx,
                                     input logic [2:0] sx, input logic [2:0] sy, input logic [3:0] hop);
    return {3'b000, ty, xmn, ymn, xmx, ymx, sx, sy, hop, 4'b0000};
  endfunction

  function automatic string pname(input int p);
    case (p)
      0: return "N";
      1: return "E";
      2: return "S";
      default: return "W";
    endcase
  endfunction

  task automatic push_exp(input int p, input logic [31:0] v);
    case (p)
      0: qn.push_back(v);
      1: qe.push_back(v);
      2: qs.push_back(v);
      default: qw.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int p, output logic ok, output logic [31:0] v);
    ok = 1'b1;
    v  = '0;
    case (p)
      0: if (qn.size() > 0) v = qn.pop_front(); else ok = 1'b0;
      1: if (qe.size() > 0) v = qe.pop_front(); else ok = 1'b0;
      2: if (qs.size() > 0) v = qs.pop_front(); else ok = 1'b0;
      default: if (qw.size() > 0) v = qw.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Monitor: every accepted output flit must match the head of its port's queue
  always @(negedge clk) begin
    logic        ok;
    logic [31:0] v;
    for (int p = 0; p < 4; p++) begin
      if (reset && outs[p] != '0 && rdys[p]) begin
        pop_exp(p, ok, v);
        n_cmp++;
        if (!ok) begin
          n_fail++;
          $display("FAIL out_%s_unexpected: got %h, required no flit", pname(p), outs[p]);
        end else if (outs[p] !== v) begin
          n_fail++;
          $display("FAIL out_%s: got %h, required %h", pname(p), outs[p], v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    n_in = '0; e_in = '0; s_in = '0; w_in = '0;
  endtask

  // Present one flit on a port for one cycle, then allow it to relay and drain
  task automatic send(input int p, input logic [31:0] f);
    case (p)
      0: n_in = f;
      1: e_in = f;
      2: s_in = f;
      default: w_in = f;
    endcase
    tick();
    clr_in();
    tick();
    tick();
  endtask

  logic [31:0] own22, own00, fa, fb, fc, f1, f2, f3;

  initial begin
    reset = 1'b0; state = 3'b000; my_x = 3'd2; my_y = 3'd2;
    clr_in();
    n_rdy = 1'b1; e_rdy = 1'b1; s_rdy = 1'b1; w_rdy = 1'b1;
    own22 = mk(3'b101, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 4'd0);
    own00 = mk(3'b101, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0);
    tick();
    tick();
    chk("reset_n_out", n_out, 32'h0);
    chk("reset_seen_count", 32'(seen_count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();

    // Announce at node (2,2)
    for (int p = 0; p < 4; p++) push_exp(p, own22);
    state = 3'b100;
    tick();
    chk("announce_not_early", n_out, 32'h0);
    tick();
    chk("announce_n_out", n_out, own22);
    chk("announce_seen_count", 32'(seen_count), 32'd1);
    tick();

    // Relay of src (3,2) arriving on E
    fa = mk(3'b101, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 4'd0);
    push_exp(0, mk(3'b101, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 4'd1));
    push_exp(2, mk(3'b101, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 4'd1));
    push_exp(3, mk(3'b101, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 4'd1));
    e_in = fa;
    tick();
    clr_in();
    chk("relay_latency_n_out", n_out, 32'h0);
    tick();
    chk("relay_e_out_zero", e_out, 32'h0);
    chk("relay_seen_count", 32'(seen_count), 32'd2);
    tick();

    // Duplicate of src (3,2) on S is dropped
    send(2, fa);
    chk("dup_seen_count", 32'(seen_count), 32'd2);

    // Simultaneous arrivals on N, E, W
    fa = mk(3'b101, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 4'd0);
    fb = mk(3'b101, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 4'd1);
    fc = mk(3'b101, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 4'd1);
    push_exp(1, mk(3'b101, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 4'd1));
    push_exp(2, mk(3'b101, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 4'd1));
    push_exp(3, mk(3'b101, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 4'd1));
    push_exp(0, mk(3'b101, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 4'd2));
    push_exp(2, mk(3'b101, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 4'd2));
    push_exp(3, mk(3'b101, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 4'd2));
    push_exp(0, mk(3'b101, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 4'd2));
    push_exp(1, mk(3'b101, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 4'd2));
    push_exp(2, mk(3'b101, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 4'd2));
    n_in = fa; e_in = fb; w_in = fc;
    tick();
    clr_in();
    tick();
    chk("simul_first_seen_count", 32'(seen_count), 32'd3);
    tick();
    tick();
    chk("simul_seen_count", 32'(seen_count), 32'd5);
    tick();

    // Hop limit: hop 9 forwards as 10, hop 10 is recorded only
    for (int p = 0; p < 4; p++) begin
      if (p != 1) push_exp(p, mk(3'b101, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 4'd10));
    end
    send(1, mk(3'b101, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 4'd9));
    chk("hop9_seen_count", 32'(seen_count), 32'd6);
    send(1, mk(3'b101, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 4'd10));
    chk("hop10_seen_count", 32'(seen_count), 32'd7);

    // Wrong type and out-of-range source are discarded
    send(1, mk(3'b100, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0));
    send(1, mk(3'b101, 3'd6, 3'd0, 3'd6, 3'd0, 3'd6, 3'd0, 4'd0));
    chk("drops_seen_count", 32'(seen_count), 32'd7);

    // Corner node (0,0): only E and S active, N input ignored
    state = 3'b000;
    tick();
    chk("leave_seen_count", 32'(seen_count), 32'd0);
    my_x = 3'd0; my_y = 3'd0;
    push_exp(1, own00);
    push_exp(2, own00);
    state = 3'b100;
    n_in = mk(3'b101, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    clr_in();
    chk("corner_overflow", 32'(overflow), 32'd0);
    chk("corner_seen_count", 32'(seen_count), 32'd1);
    chk("corner_n_out", n_out, 32'h0);
    chk("corner_w_out", w_out, 32'h0);

    // Backpressure on N at node (2,2), FIFO overflow, then drain and abort
    state = 3'b000;
    n_rdy = 1'b0;
    tick();
    my_x = 3'd2; my_y = 3'd2;
    for (int p = 0; p < 4; p++) push_exp(p, own22);
    state = 3'b100;
    tick();
    tick();
    tick();
    f1 = mk(3'b101, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 4'd0);
    f2 = mk(3'b101, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 4'd0);
    f3 = mk(3'b101, 3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd3, 4'd0);
    w_in = f1;
    tick();
    chk("bp_no_overflow_yet", 32'(overflow), 32'd0);
    w_in = f2;
    tick();
    chk("bp_n_out_held", n_out, own22);
    w_in = f3;
    tick();
    clr_in();
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_seen_count", 32'(seen_count), 32'd1);
    for (int p = 0; p < 3; p++) push_exp(p, mk(3'b101, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 4'd1));
    n_rdy = 1'b1;
    tick();
    chk("drain_seen_count", 32'(seen_count), 32'd2);
    state = 3'b000;
    tick();
    chk("abort_n_out", n_out, 32'h0);
    chk("abort_e_out", e_out, 32'h0);
    chk("abort_s_out", s_out, 32'h0);
    chk("abort_seen_count", 32'(seen_count), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    tick();
    tick();

    chk("queue_N_drained", 32'(qn.size()), 32'd0);
    chk("queue_E_drained", 32'(qe.size()), 32'd0);
    chk("queue_S_drained", 32'(qs.size()), 32'd0);
    chk("queue_W_drained", 32'(qw.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
